// File: rtl/vga_pkg.sv
// Shared types and constants for the programmable video timing generator.
package vga_pkg;

    // Field width of the mode record; the generator's CW must not exceed it.
    localparam int VGA_FW = 12;

    typedef struct packed {
        logic [VGA_FW-1:0] hvis;
        logic [VGA_FW-1:0] hfp;
        logic [VGA_FW-1:0] hsw;
        logic [VGA_FW-1:0] hbp;
        logic [VGA_FW-1:0] vvis;
        logic [VGA_FW-1:0] vfp;
        logic [VGA_FW-1:0] vsw;
        logic [VGA_FW-1:0] vbp;
        logic              hpol;
        logic              vpol;
    } vga_mode_t;

    localparam vga_mode_t MODE_640x480_60 = '{
        hvis: VGA_FW'(640), hfp: VGA_FW'(16), hsw: VGA_FW'(96), hbp: VGA_FW'(48),
        vvis: VGA_FW'(480), vfp: VGA_FW'(10), vsw: VGA_FW'(2),  vbp: VGA_FW'(33),
        hpol: 1'b0,         vpol: 1'b0
    };

    function automatic vga_mode_t make_mode(input int hvis, input int hfp, input int hsw,
                                            input int hbp, input int vvis, input int vfp,
                                            input int vsw, input int vbp, input int hpol,
                                            input int vpol);
        vga_mode_t m;
        m.hvis = VGA_FW'(hvis);
        m.hfp  = VGA_FW'(hfp);
        m.hsw  = VGA_FW'(hsw);
        m.hbp  = VGA_FW'(hbp);
        m.vvis = VGA_FW'(vvis);
        m.vfp  = VGA_FW'(vfp);
        m.vsw  = VGA_FW'(vsw);
        m.vbp  = VGA_FW'(vbp);
        m.hpol = hpol[0];
        m.vpol = vpol[0];
        return m;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Config write port and raster outputs of the video timing generator.
interface vga_timing_gen_if #(
    parameter int CW = 12
);
    logic          cfg_wr;
    logic [CW-1:0] cfg_hvis, cfg_hfp, cfg_hsw, cfg_hbp;
    logic [CW-1:0] cfg_vvis, cfg_vfp, cfg_vsw, cfg_vbp;
    logic          cfg_hpol, cfg_vpol;
    logic          cfg_pending, cfg_err;
    logic [CW-1:0] hcount, vcount;
    logic          hsync, vsync, de, sof, eol;
    logic          hsync_d, vsync_d, de_d;

    modport master (
        output cfg_wr, cfg_hvis, cfg_hfp, cfg_hsw, cfg_hbp,
               cfg_vvis, cfg_vfp, cfg_vsw, cfg_vbp, cfg_hpol, cfg_vpol,
        input  cfg_pending, cfg_err, hcount, vcount, hsync, vsync, de, sof, eol,
               hsync_d, vsync_d, de_d
    );

    modport slave (
        input  cfg_wr, cfg_hvis, cfg_hfp, cfg_hsw, cfg_hbp,
               cfg_vvis, cfg_vfp, cfg_vsw, cfg_vbp, cfg_hpol, cfg_vpol,
        output cfg_pending, cfg_err, hcount, vcount, hsync, vsync, de, sof, eol,
               hsync_d, vsync_d, de_d
    );
endinterface

// File: rtl/vga_delay_line.sv
// Resettable shift register; DEPTH = 0 degenerates to a wire.
module vga_delay_line #(
    parameter int               WIDTH   = 1,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk_pix,
    input  logic             resetn,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            assign o_data = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge clk_pix or negedge resetn) begin
                if (!resetn) begin
                    for (int i = 0; i < DEPTH; i++) r_stage[i] <= RST_VAL;
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Runtime-programmable raster timing generator; new modes take effect only at
// the frame boundary, and delayed copies of sync/de feed a downstream pipeline.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CW       = 12,
    parameter int PIPE_LAT = 2,
    parameter int D_HVIS   = 640,
    parameter int D_HFP    = 16,
    parameter int D_HSW    = 96,
    parameter int D_HBP    = 48,
    parameter int D_VVIS   = 480,
    parameter int D_VFP    = 10,
    parameter int D_VSW    = 2,
    parameter int D_VBP    = 33,
    parameter int D_HPOL   = 0,
    parameter int D_VPOL   = 0
) (
    input  logic           clk_pix,
    input  logic           resetn,
    vga_timing_gen_if.slave bus
);

    localparam int               DW        = CW + 2;
    localparam logic [DW-1:0]    MAX_TOTAL = DW'(2 ** CW);
    localparam vga_mode_t        DEF_MODE  = make_mode(D_HVIS, D_HFP, D_HSW, D_HBP,
                                                       D_VVIS, D_VFP, D_VSW, D_VBP,
                                                       D_HPOL, D_VPOL);
    localparam logic             HS_IDLE   = ~DEF_MODE.hpol;
    localparam logic             VS_IDLE   = ~DEF_MODE.vpol;

    function automatic logic [DW-1:0] ext(input logic [VGA_FW-1:0] f);
        return DW'(f[CW-1:0]);
    endfunction

    function automatic logic [DW-1:0] sum4(input logic [VGA_FW-1:0] a, input logic [VGA_FW-1:0] b,
                                           input logic [VGA_FW-1:0] c, input logic [VGA_FW-1:0] d);
        return ext(a) + ext(b) + ext(c) + ext(d);
    endfunction

    vga_mode_t     r_act, r_pend;
    logic          r_pending, r_err;
    logic [CW-1:0] r_hcount, r_vcount;
    logic          r_hsync, r_vsync, r_de, r_sof, r_eol;

    vga_mode_t     w_cfg_mode, w_nmode;
    logic [DW-1:0] w_act_ht, w_act_vt, w_cfg_ht, w_cfg_vt;
    logic [DW-1:0] w_hs0, w_hs1, w_ht, w_vs0, w_vs1, w_hn, w_vn;
    logic          w_cfg_ok, w_hlast, w_vlast, w_boundary;
    logic [CW-1:0] w_hnext, w_vnext;
    logic          w_hs_n, w_vs_n, w_de_n, w_sof_n, w_eol_n;
    logic [2:0]    w_dly;

    always_comb begin
        w_cfg_mode.hvis = VGA_FW'(bus.cfg_hvis);
        w_cfg_mode.hfp  = VGA_FW'(bus.cfg_hfp);
        w_cfg_mode.hsw  = VGA_FW'(bus.cfg_hsw);
        w_cfg_mode.hbp  = VGA_FW'(bus.cfg_hbp);
        w_cfg_mode.vvis = VGA_FW'(bus.cfg_vvis);
        w_cfg_mode.vfp  = VGA_FW'(bus.cfg_vfp);
        w_cfg_mode.vsw  = VGA_FW'(bus.cfg_vsw);
        w_cfg_mode.vbp  = VGA_FW'(bus.cfg_vbp);
        w_cfg_mode.hpol = bus.cfg_hpol;
        w_cfg_mode.vpol = bus.cfg_vpol;
    end

    assign w_cfg_ht = sum4(w_cfg_mode.hvis, w_cfg_mode.hfp, w_cfg_mode.hsw, w_cfg_mode.hbp);
    assign w_cfg_vt = sum4(w_cfg_mode.vvis, w_cfg_mode.vfp, w_cfg_mode.vsw, w_cfg_mode.vbp);
    assign w_cfg_ok = (bus.cfg_hvis != '0) && (bus.cfg_hfp != '0) && (bus.cfg_hsw != '0) &&
                      (bus.cfg_hbp  != '0) && (bus.cfg_vvis != '0) && (bus.cfg_vfp != '0) &&
                      (bus.cfg_vsw  != '0) && (bus.cfg_vbp  != '0) &&
                      (w_cfg_ht <= MAX_TOTAL) && (w_cfg_vt <= MAX_TOTAL);

    assign w_act_ht   = sum4(r_act.hvis, r_act.hfp, r_act.hsw, r_act.hbp);
    assign w_act_vt   = sum4(r_act.vvis, r_act.vfp, r_act.vsw, r_act.vbp);
    assign w_hlast    = (DW'(r_hcount) == w_act_ht - DW'(1));
    assign w_vlast    = (DW'(r_vcount) == w_act_vt - DW'(1));
    assign w_boundary = w_hlast && w_vlast;
    assign w_hnext    = w_hlast ? '0 : r_hcount + CW'(1);
    assign w_vnext    = !w_hlast ? r_vcount : (w_vlast ? '0 : r_vcount + CW'(1));

    // Decode the coordinate about to be loaded, using the mode that will be
    // active then, so every registered output lines up with the counters.
    always_comb begin
        w_nmode = r_act;
        if (w_boundary && r_pending) w_nmode = r_pend;
        w_hs0   = ext(w_nmode.hvis) + ext(w_nmode.hfp);
        w_hs1   = w_hs0 + ext(w_nmode.hsw);
        w_ht    = w_hs1 + ext(w_nmode.hbp);
        w_vs0   = ext(w_nmode.vvis) + ext(w_nmode.vfp);
        w_vs1   = w_vs0 + ext(w_nmode.vsw);
        w_hn    = DW'(w_hnext);
        w_vn    = DW'(w_vnext);
        w_de_n  = (w_hn < ext(w_nmode.hvis)) && (w_vn < ext(w_nmode.vvis));
        w_hs_n  = w_nmode.hpol ~^ ((w_hn >= w_hs0) && (w_hn < w_hs1));
        w_vs_n  = w_nmode.vpol ~^ ((w_vn >= w_vs0) && (w_vn < w_vs1));
        w_sof_n = (w_hnext == '0) && (w_vnext == '0);
        w_eol_n = (w_hn == w_ht - DW'(1));
    end

    // A write landing on the boundary cycle wins over the pending clear, so the
    // old pending mode goes active while the new one waits for the next frame.
    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_act     <= DEF_MODE;
            r_pend    <= DEF_MODE;
            r_pending <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_err <= bus.cfg_wr && !w_cfg_ok;
            if (w_boundary && r_pending) r_act <= r_pend;
            if (bus.cfg_wr && w_cfg_ok) begin
                r_pend    <= w_cfg_mode;
                r_pending <= 1'b1;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk_pix or negedge resetn) begin
        if (!resetn) begin
            r_hcount <= '0;
            r_vcount <= '0;
            r_hsync  <= HS_IDLE;
            r_vsync  <= VS_IDLE;
            r_de     <= 1'b1;
            r_sof    <= 1'b1;
            r_eol    <= 1'b0;
        end else begin
            r_hcount <= w_hnext;
            r_vcount <= w_vnext;
            r_hsync  <= w_hs_n;
            r_vsync  <= w_vs_n;
            r_de     <= w_de_n;
            r_sof    <= w_sof_n;
            r_eol    <= w_eol_n;
        end
    end

    vga_delay_line #(
        .WIDTH  (3),
        .DEPTH  (PIPE_LAT),
        .RST_VAL({HS_IDLE, VS_IDLE, 1'b0})
    ) u_delay (
        .clk_pix(clk_pix),
        .resetn (resetn),
        .i_data ({r_hsync, r_vsync, r_de}),
        .o_data (w_dly)
    );

    assign bus.cfg_pending = r_pending;
    assign bus.cfg_err     = r_err;
    assign bus.hcount      = r_hcount;
    assign bus.vcount      = r_vcount;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.de          = r_de;
    assign bus.sof         = r_sof;
    assign bus.eol         = r_eol;
    assign bus.hsync_d     = w_dly[2];
    assign bus.vsync_d     = w_dly[1];
    assign bus.de_d        = w_dly[0];

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised video timing generator and successor to the fixed 640x480 timing block. It produces raster counters, sync, data-enable and frame/line strobes for any mode loaded at runtime through a config write port. New modes are applied only at frame boundaries, and sync polarity is selectable. A delay line supplies copies of the sync and enable signals aligned to a downstream pixel pipeline of configurable latency.

Parameters:
- CW, 12, width of counters and timing fields; max total 2^CW.
- PIPE_LAT, 2, delay in clk_pix cycles of the hsync_d/vsync_d/de_d outputs; 0 means they equal the undelayed outputs.
- Reset mode, as eight parameters: D_HVIS 640, D_HFP 16, D_HSW 96, D_HBP 48, D_VVIS 480, D_VFP 10, D_VSW 2, D_VBP 33.
- D_HPOL, 0, reset hsync polarity (0 = active low).
- D_VPOL, 0, reset vsync polarity (0 = active low).

Ports:
- clk_pix  in  1  pixel clock
- resetn  in  1  asynchronous active-low reset
- cfg_wr  in  1  one-cycle pulse; captures all cfg_* inputs
- cfg_hvis, cfg_hfp, cfg_hsw, cfg_hbp  in  CW each  horizontal visible, front porch, sync width, back porch
- cfg_vvis, cfg_vfp, cfg_vsw, cfg_vbp  in  CW each  vertical equivalents
- cfg_hpol, cfg_vpol  in  1 each  sync polarity (1 = active high)
- cfg_pending  out  1  a mode is captured and waiting for the frame boundary
- cfg_err  out  1  one-cycle pulse; last write was rejected
- hcount, vcount  out  CW each  current pixel coordinate
- hsync, vsync, de  out  1 each  aligned with hcount/vcount
- sof  out  1  high at coordinate (0,0)
- eol  out  1  high at the last pixel of every line
- hsync_d, vsync_d, de_d  out  1 each  hsync/vsync/de delayed PIPE_LAT cycles

Behaviour:
- Reset: resetn is asynchronous and active-low; clock is clk_pix.
  - Active mode loads the D_* parameters; pending is cleared.
  - hcount = vcount = 0; sof = 1; eol = 0; de = 1.
  - hsync = ~D_HPOL and vsync = ~D_VPOL (inactive level).
  - cfg_err = 0; the delay line is filled with the inactive sync level and de = 0.
- Derived values, all CW+2 bits, computed from the active registers:
  - HT = hvis + hfp + hsw + hbp.
  - HS0 = hvis + hfp.
  - HS1 = HS0 + hsw.
  - Vertical values VT, VS0, VS1 are formed the same way.
- Counters:
  - hcount increments each cycle and wraps to 0 after HT-1.
  - On that wrap, vcount increments and wraps to 0 after VT-1.
- Decode (registered; all outputs are mutually aligned with hcount/vcount, with zero skew between them):
  - de = (hcount < hvis) && (vcount < vvis).
  - hsync = hpol XNOR (HS0 <= hcount < HS1).
  - vsync = vpol XNOR (VS0 <= vcount < VS1); vsync changes with vcount at line start.
  - sof = (hcount == 0) && (vcount == 0).
  - eol = (hcount == HT-1).
- Config write:
  - When cfg_wr = 1, validate the fields:
    - every field must be >= 1;
    - HT <= 2^CW and VT <= 2^CW.
  - Valid write: latch the fields into the pending registers and set cfg_pending = 1. A second write before the boundary overwrites the pending mode.
  - Invalid write: pulse cfg_err next cycle; pending registers and cfg_pending are unchanged.
- Frame boundary is the cycle where hcount == HT-1 and vcount == VT-1.
  - If cfg_pending = 1, active <= pending and cfg_pending clears.
  - Counters wrap to 0 and the next cycle decodes (0,0) with the new mode.
- cfg_wr coinciding with the boundary: the old pending mode is applied, the new write becomes pending for the following frame, and cfg_pending stays 1.
- The active mode never changes mid-frame.
- Reset mid-frame returns to the reset mode immediately and discards any pending mode.

Decomposition:
- Shared package vga_pkg:
  - struct vga_mode_t holding the 8 fields and 2 polarities, parametrised by CW;
  - constant MODE_640x480_60;
  - field-width constant.
- Sub-module vga_delay_line (parameters WIDTH, DEPTH; a resettable shift register) implements the _d outputs, with DEPTH = 0 acting as a passthrough.

Test Plan:
1. Reset, default mode -> line = 800 clocks; hsync low for hcount 656..751; de high for hcount 0..639 and vcount 0..479; vsync low for lines 490..491; sof every 420000 clocks.
2. Mid-frame write of an 800x600 mode (40/128/88, 1/4/23, pol 1/1) -> cfg_pending = 1; current frame completes at 420000 clocks; the next frame has HT = 1056 and VT = 628, with hsync high for hcount 840..967; pending clears at the boundary.
3. Write with cfg_hsw = 0, then with HT = 4097 at CW = 12 -> cfg_err pulses once for each; cfg_pending and the active mode are unchanged.
4. Two writes to pending, the second on the exact boundary cycle -> the first is applied at the boundary, the second is applied one frame later, and cfg_pending is high between them.
5. PIPE_LAT = 3 -> hsync_d, vsync_d and de_d equal hsync, vsync and de delayed exactly 3 cycles, including across a mode switch.
6. resetn asserted at hcount = 300, vcount = 200 with a mode pending -> outputs return to their reset values asynchronously, pending is discarded, and the default 640x480 timing resumes from (0,0).
